// File: rtl/core_types_pkg.sv
// Shared front-end predictor types and sizing constants.
// Holds the local-history-table geometry and the set-index hash.
package core_types_pkg;

    localparam int LHT_ENTRIES_PER_BLOCK = 8;
    localparam int LH_LENGTH             = 8;
    localparam int ASID_WIDTH            = 9;
    localparam int LHT_INDEX_WIDTH       = 5;
    localparam int LHT_SETS              = 1 << LHT_INDEX_WIDTH;
    localparam int LHT_SLOT_WIDTH        = $clog2(LHT_ENTRIES_PER_BLOCK);

    typedef logic [LH_LENGTH-1:0]                  lh_t;
    typedef lh_t  [LHT_ENTRIES_PER_BLOCK-1:0]      lh_block_t;
    typedef logic [LHT_INDEX_WIDTH-1:0]            lht_idx_t;
    typedef logic [LHT_SLOT_WIDTH-1:0]             lht_slot_t;

    // Reads and updates must agree on this hash or updates land in the wrong set.
    function automatic lht_idx_t lht_hash(input lht_idx_t pc_set, input lht_idx_t asid_lo);
        return pc_set ^ asid_lo;
    endfunction

endpackage

// File: rtl/lht_ram.sv
// 32-set x 8-slot local-history RAM, one read and one slot-masked write per cycle.
// Latency: 1 cycle read (registered); backpressure: none, output holds when rd_en is low.
module lht_ram
    import core_types_pkg::*;
#(
    parameter bit WR_BYPASS = 1'b0
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             rd_en,
    input  lht_idx_t                         rd_idx,
    output lh_block_t                        rd_dat,
    input  logic [LHT_ENTRIES_PER_BLOCK-1:0] wr_en,
    input  lht_idx_t                         wr_idx,
    input  lh_t                              wr_dat
);

    lh_block_t mem [LHT_SETS];
    lh_block_t rd_word;

    // Same-set write merges into the read word only when bypass is built in.
    always_comb begin
        rd_word = mem[rd_idx];
        if (WR_BYPASS && (wr_idx == rd_idx)) begin
            for (int k = 0; k < LHT_ENTRIES_PER_BLOCK; k++) begin
                if (wr_en[k]) rd_word[k] = wr_dat;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < LHT_ENTRIES_PER_BLOCK; k++) begin
            if (wr_en[k]) mem[wr_idx][k] <= wr_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= rd_word;
        end
    end

endmodule

// File: rtl/lht.sv
// Local History Table: one 8-bit LH per 2B slot of the fetch block, set = PC[8:4]^ASID[4:0].
// Latency: 1 cycle; backpressure: none, response holds while valid_REQ is low.
// Optional LHT_BYPASS_EN: same-cycle update to the read set forwards into the response.
module lht
    import core_types_pkg::*;
(
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  valid_REQ,
    input  logic [31:0]           full_PC_REQ,
    input  logic [ASID_WIDTH-1:0] ASID_REQ,
    output lh_block_t             LH_by_instr_RESP,
    input  logic                  update0_valid,
    input  logic [31:0]           update0_start_full_PC,
    input  logic [ASID_WIDTH-1:0] update0_ASID,
    input  lh_t                   update0_LH
);

`ifdef LHT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    lht_idx_t                         rd_idx;
    lht_idx_t                         wr_idx;
    lht_slot_t                        wr_slot;
    logic [LHT_ENTRIES_PER_BLOCK-1:0] wr_en;
    logic                             rd_en;

    assign rd_idx  = lht_hash(full_PC_REQ[8:4], ASID_REQ[4:0]);
    assign wr_idx  = lht_hash(update0_start_full_PC[8:4], update0_ASID[4:0]);
    assign wr_slot = update0_start_full_PC[3:1];
    assign rd_en   = valid_REQ;

    // Updates arriving during reset are dropped rather than written.
    always_comb begin
        wr_en = '0;
        if (update0_valid && nRST) wr_en[wr_slot] = 1'b1;
    end

    logic unused_bits;
    assign unused_bits = ^{full_PC_REQ[31:9], full_PC_REQ[3:0], ASID_REQ[8:5],
                           update0_start_full_PC[31:9], update0_start_full_PC[0],
                           update0_ASID[8:5]};

    lht_ram #(
        .WR_BYPASS (BYPASS)
    ) u_ram (
        .CLK    (CLK),
        .nRST   (nRST),
        .rd_en  (rd_en),
        .rd_idx (rd_idx),
        .rd_dat (LH_by_instr_RESP),
        .wr_en  (wr_en),
        .wr_idx (wr_idx),
        .wr_dat (update0_LH)
    );

endmodule

// File: tb/tb_lht.sv
// Self-checking bench for lht: scoreboard of expected responses against a reference table.
module tb_lht;
    import core_types_pkg::*;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  valid_REQ;
    logic [31:0]           full_PC_REQ;
    logic [ASID_WIDTH-1:0] ASID_REQ;
    lh_block_t             LH_by_instr_RESP;
    logic                  update0_valid;
    logic [31:0]           update0_start_full_PC;
    logic [ASID_WIDTH-1:0] update0_ASID;
    lh_t                   update0_LH;

    int errors = 0;
    int checks = 0;

    lh_block_t exp_q [$];
    lh_t       mdl [32][8];

    lht dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .valid_REQ             (valid_REQ),
        .full_PC_REQ           (full_PC_REQ),
        .ASID_REQ              (ASID_REQ),
        .LH_by_instr_RESP      (LH_by_instr_RESP),
        .update0_valid         (update0_valid),
        .update0_start_full_PC (update0_start_full_PC),
        .update0_ASID          (update0_ASID),
        .update0_LH            (update0_LH)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int tb_set(input logic [31:0] pc, input logic [8:0] asid);
        return int'(pc[8:4]) ^ int'(asid[4:0]);
    endfunction

    function automatic lh_block_t model_block(input int s);
        lh_block_t b;
        for (int k = 0; k < 8; k++) b[k] = mdl[s][k];
        return b;
    endfunction

    task automatic test_reset();
        nRST = 1'b0;
        tick();
        checks++;
        if (LH_by_instr_RESP !== 64'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", LH_by_instr_RESP, 64'h0);
        end
        nRST = 1'b1;
        tick();
        checks++;
        if (LH_by_instr_RESP !== 64'h0) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", LH_by_instr_RESP, 64'h0);
        end
    endtask

    task automatic test_update_chain();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            update0_valid         = 1'b1;
            update0_start_full_PC = {23'd0, iv[7:3], iv[2:0], 1'b0};
            update0_ASID          = iv[0] ? 9'h01F : 9'h000;
            update0_LH            = iv;
            mdl[tb_set(update0_start_full_PC, update0_ASID)][iv[2:0]] = iv;
            tick();
            checks++;
            if (LH_by_instr_RESP !== 64'h0) begin
                errors++;
                $display("FAIL update_quiet i=%0d: got %h want %h", i, LH_by_instr_RESP, 64'h0);
            end
        end
        update0_valid = 1'b0;
    endtask

    task automatic test_read_chain(input logic [8:0] asid, input lh_block_t last_exp);
        lh_block_t got, exp;
        for (int s = 0; s < 32; s++) begin
            valid_REQ   = 1'b1;
            full_PC_REQ = 32'(s) << 4;
            ASID_REQ    = asid;
            exp_q.push_back(model_block(tb_set(full_PC_REQ, ASID_REQ)));
            tick();
            got = LH_by_instr_RESP;
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL read_chain asid=%h set=%0d: got %h want %h", asid, s, got, exp);
            end
        end
        checks++;
        if (LH_by_instr_RESP !== last_exp) begin
            errors++;
            $display("FAIL read_last asid=%h: got %h want %h", asid, LH_by_instr_RESP, last_exp);
        end
        valid_REQ = 1'b0;
    endtask

    task automatic test_hold();
        valid_REQ   = 1'b0;
        full_PC_REQ = 32'h0000_0030;
        ASID_REQ    = 9'h005;
        tick();
        checks++;
        if (LH_by_instr_RESP !== 64'h07fe05fc03fa01f8) begin
            errors++;
            $display("FAIL hold: got %h want %h", LH_by_instr_RESP, 64'h07fe05fc03fa01f8);
        end
    endtask

    task automatic test_collision();
        lh_block_t exp, got;
        valid_REQ             = 1'b1;
        full_PC_REQ           = 32'h0000_0030;
        ASID_REQ              = 9'h000;
        update0_valid         = 1'b1;
        update0_start_full_PC = 32'h0000_0034;
        update0_ASID          = 9'h000;
        update0_LH            = 8'hAA;
        exp = model_block(3);
`ifdef LHT_BYPASS_EN
        exp[2] = 8'hAA;
`endif
        exp_q.push_back(exp);
        mdl[3][2] = 8'hAA;
        tick();
        update0_valid = 1'b0;
        got = LH_by_instr_RESP;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL collision: got %h want %h", got, exp);
        end
        exp_q.push_back(model_block(3));
        tick();
        got = LH_by_instr_RESP;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got[2] !== 8'hAA) begin
            errors++;
            $display("FAIL after_collision: got %h want %h", got, exp);
        end
        valid_REQ = 1'b0;
    endtask

    task automatic test_reset_drop();
        lh_block_t exp, got;
        nRST                  = 1'b0;
        valid_REQ             = 1'b1;
        full_PC_REQ           = 32'h0000_0030;
        ASID_REQ              = 9'h000;
        update0_valid         = 1'b1;
        update0_start_full_PC = 32'h0000_0034;
        update0_ASID          = 9'h000;
        update0_LH            = 8'h55;
        tick();
        checks++;
        if (LH_by_instr_RESP !== 64'h0) begin
            errors++;
            $display("FAIL reset_midstream: got %h want %h", LH_by_instr_RESP, 64'h0);
        end
        nRST          = 1'b1;
        update0_valid = 1'b0;
        exp_q.push_back(model_block(3));
        tick();
        got = LH_by_instr_RESP;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_drop_update: got %h want %h", got, exp);
        end
        valid_REQ = 1'b0;
    endtask

    initial begin
        nRST                  = 1'b0;
        valid_REQ             = 1'b0;
        full_PC_REQ           = '0;
        ASID_REQ              = '0;
        update0_valid         = 1'b0;
        update0_start_full_PC = '0;
        update0_ASID          = '0;
        update0_LH            = '0;
        for (int s = 0; s < 32; s++)
            for (int k = 0; k < 8; k++) mdl[s][k] = 8'h00;

        test_reset();
        test_update_chain();
        test_read_chain(9'h000, 64'h07fe05fc03fa01f8);
        test_hold();
        test_read_chain(9'h01F, 64'hff06fd04fb02f900);
        test_collision();
        test_reset_drop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
